uart_tx_sequencer: RTL and testbench

//   Drives a single-byte UART transmitter (Tx_En_Sig/Tx_Done_Sig handshake) with a multi-byte message.
//   The message is held in an internal, host-writable byte buffer.
//   A message is sent periodically (every T_PERIOD clocks) or on demand (Start_Sig).

---
 rtl/uart_tx_sequencer_if.sv | 43 ++++
 rtl/uart_tx_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer_if
//   Groups the host-side control/buffer-write signals and the uart_tx core
//   handshake of uart_tx_sequencer into one bundle.
//
//   Handshake with the uart_tx core (Tx_En_Sig / Tx_Done_Sig):
//     Tx_En_Sig acts as "valid": it rises with Tx_Data already stable, stays
//     high and Tx_Data stays constant until the core answers. Tx_Done_Sig acts
//     as a one-cycle "ready/accept" pulse that ends the byte. Tx_En_Sig
//     drops on the edge that samples Tx_Done_Sig. A Tx_Done_Sig pulse while
//     Tx_En_Sig is low carries no meaning and is ignored.
//
//   Modports:
//     master : host / uart_tx side (drives control, write port, Tx_Done_Sig)
//     slave  : the sequencer (drives Tx_En_Sig, Tx_Data and status pulses)
// ---------------------------------------------------------------------------
interface uart_tx_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              Mode;
  logic              Start_Sig;
  logic [ADDR_W:0]   Msg_Len;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;
  logic              Tx_Done_Sig;
  logic              Tx_En_Sig;
  logic [DATA_W-1:0] Tx_Data;
  logic              Busy;
  logic              Frame_Done_Sig;
  logic              Overrun_Sig;

  modport master (
    output Mode, Start_Sig, Msg_Len, Wr_En, Wr_Addr, Wr_Data, Tx_Done_Sig,
    input  Tx_En_Sig, Tx_Data, Busy, Frame_Done_Sig, Overrun_Sig
  );

  modport slave (
    input  Mode, Start_Sig, Msg_Len, Wr_En, Wr_Addr, Wr_Data, Tx_Done_Sig,
    output Tx_En_Sig, Tx_Data, Busy, Frame_Done_Sig, Overrun_Sig
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
//   Feeds a single-byte uart_tx core with a multi-byte message held in an
//   internal host-writable byte buffer. A frame is started either every
//   T_PERIOD clocks (Mode=0) or by a Start_Sig pulse (Mode=1). One byte is
//   handed to the core per Tx_En_Sig / Tx_Done_Sig handshake.
//
// Ports:
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-high reset
//   bus        : uart_tx_sequencer_if.slave
//                  in : Mode, Start_Sig, Msg_Len, Wr_En, Wr_Addr, Wr_Data,
//                       Tx_Done_Sig
//                  out: Tx_En_Sig, Tx_Data, Busy, Frame_Done_Sig, Overrun_Sig
//   state_dbg  : current FSM state (IDLE=0, LOAD=1, SEND=2, DONE=3)
// ---------------------------------------------------------------------------
module uart_tx_sequencer #(
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 4,
  parameter int              T_PERIOD  = 50_000_000,
  parameter logic [DATA_W-1:0] INIT_BYTE = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_sequencer_if.slave   bus,
  output logic [1:0]           state_dbg
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = (T_PERIOD > 2) ? $clog2(T_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(T_PERIOD - 1);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   idx_q,        idx_d;
  logic [LEN_W-1:0]    len_q,        len_d;
  logic                tx_en_q,      tx_en_d;
  logic [DATA_W-1:0]   tx_data_q,    tx_data_d;
  logic                busy_q,       busy_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q,    overrun_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                trigger;
  logic [LEN_W-1:0]    len_eff;
  logic                last_byte;
  logic                wr_ok;

  // -------------------------------------------------------------------------
  // Period counter. Held at 0 in on-demand mode so that returning to
  // periodic mode always gives a full T_PERIOD before the first trigger.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (bus.Mode) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign trigger = (!bus.Mode && (cnt_q == CNT_LAST)) ||
                   ( bus.Mode && bus.Start_Sig);

  // Frame length is clipped to the buffer depth.
  assign len_eff   = (bus.Msg_Len > DEPTH_LEN) ? DEPTH_LEN : bus.Msg_Len;
  assign last_byte = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  // -------------------------------------------------------------------------
  // Buffer write port. Writes land in mem_q on the next edge, so a LOAD of
  // the same address in the write cycle still sees the old contents, and a
  // byte already copied into Tx_Data is not disturbed.
  // -------------------------------------------------------------------------
  assign wr_ok = bus.Wr_En && ({1'b0, bus.Wr_Addr} < DEPTH_LEN);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[bus.Wr_Addr] = bus.Wr_Data;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM next-state / registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    tx_en_d      = tx_en_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    // Any trigger outside IDLE is dropped and reported.
    overrun_d    = trigger && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // A zero-length request is silently ignored.
        if (trigger && (len_eff != '0)) begin
          state_d = S_LOAD;
          len_d   = len_eff;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_LOAD: begin
        tx_data_d = mem_q[idx_q];
        tx_en_d   = 1'b1;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (bus.Tx_Done_Sig) begin
          tx_en_d = 1'b0;
          if (last_byte) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      S_DONE: begin
        idx_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= INIT_BYTE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= '0;
      mem_q        <= '{default: INIT_BYTE};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.Tx_En_Sig      = tx_en_q;
  assign bus.Tx_Data        = tx_data_q;
  assign bus.Busy           = busy_q;
  assign bus.Frame_Done_Sig = frame_done_q;
  assign bus.Overrun_Sig    = overrun_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int T_PERIOD = 20;
  localparam logic [7:0] INIT = 8'hA5;

  // ---------------------------------------------------------------- clock/reset
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_tx_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .T_PERIOD(T_PERIOD), .INIT_BYTE(INIT)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                len_q[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  int checks = 0, errors = 0;
  int fd_seen = 0, ovr_seen = 0, frames_exp = 0, ovr_exp = 0;
  int t_trig = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_len(input int ml);
    return (ml > DEPTH) ? DEPTH : ml;
  endfunction

  // uart_tx core model: Tx_Done_Sig pulses 5 cycles after Tx_En_Sig rises.
  initial begin
    int  ucnt = 0;
    logic uprev = 1'b0;
    bus.Tx_Done_Sig = 1'b0;
    forever begin
      @(negedge CLK);
      bus.Tx_Done_Sig = 1'b0;
      if (RST) begin
        ucnt  = 0;
        uprev = 1'b0;
      end else begin
        if (bus.Tx_En_Sig && !uprev) ucnt = 1;
        else if (ucnt > 0)           ucnt++;
        if (ucnt == 6) begin
          bus.Tx_Done_Sig = 1'b1;
          ucnt = 0;
        end
        uprev = bus.Tx_En_Sig;
      end
    end
  end

  // Output monitor: byte order/content, hold while enabled, one-cycle gap,
  // bytes per frame, and pulse counts.
  initial begin
    logic              prev_en = 1'b0;
    logic [DATA_W-1:0] cur_exp = '0;
    int                nbytes = 0;
    int                gap = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_en = 1'b0;
        nbytes  = 0;
        gap     = 0;
      end else begin
        if (bus.Tx_En_Sig && !prev_en) begin
          if (exp_q.size() == 0) begin
            check_eq("byte_expected", exp_q.size(), 1);
          end else begin
            cur_exp = exp_q.pop_front();
            check_eq("tx_data", 32'(bus.Tx_Data), 32'(cur_exp));
          end
          if (nbytes > 0) check_eq("en_gap", gap, 1);
          nbytes++;
          gap = 0;
        end else if (bus.Tx_En_Sig) begin
          check_eq("tx_data_hold", 32'(bus.Tx_Data), 32'(cur_exp));
        end else begin
          gap++;
        end
        if (bus.Frame_Done_Sig) begin
          fd_seen++;
          if (len_q.size() == 0) check_eq("frame_expected", len_q.size(), 1);
          else                   check_eq("frame_bytes", nbytes, len_q.pop_front());
          nbytes = 0;
        end
        if (bus.Overrun_Sig) ovr_seen++;
        prev_en = bus.Tx_En_Sig;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = ADDR_W'(a);
    bus.Wr_Data = d;
    @(negedge CLK);
    bus.Wr_En = 1'b0;
    if (a < DEPTH) shadow[a] = d;
  endtask

  task automatic pulse_start();
    bus.Start_Sig = 1'b1;
    @(negedge CLK);
    bus.Start_Sig = 1'b0;
  endtask

  // Issues an accepted-frame request and records what it must produce.
  task automatic start_frame(input int ml);
    int n;
    n = eff_len(ml);
    bus.Msg_Len = (ADDR_W + 1)'(ml);
    if (n > 0) begin
      for (int i = 0; i < n; i++) exp_q.push_back(shadow[i]);
      len_q.push_back(n);
      frames_exp++;
    end
    t_trig = cyc;
    pulse_start();
  endtask

  task automatic wait_en_rise(input string tag);
    int n = 0;
    while (bus.Tx_En_Sig && n < 200)  begin @(negedge CLK); n++; end
    while (!bus.Tx_En_Sig && n < 200) begin @(negedge CLK); n++; end
    check_eq(tag, 32'(bus.Tx_En_Sig), 1);
  endtask

  task automatic wait_fd(input int n);
    int k = 0;
    while (fd_seen < n && k < 300) begin @(negedge CLK); k++; end
    check_eq("frame_count", fd_seen, n);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int t0, ml, n, k;
    bus.Mode = 1'b0;  bus.Start_Sig = 1'b0;  bus.Msg_Len = 3'd1;
    bus.Wr_En = 1'b0; bus.Wr_Addr = '0;      bus.Wr_Data = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = INIT;

    // Reset values
    repeat (3) @(negedge CLK);
    check_eq("rst_en",      32'(bus.Tx_En_Sig), 0);
    check_eq("rst_data",    32'(bus.Tx_Data), 32'(INIT));
    check_eq("rst_busy",    32'(bus.Busy), 0);
    check_eq("rst_fdone",   32'(bus.Frame_Done_Sig), 0);
    check_eq("rst_overrun", 32'(bus.Overrun_Sig), 0);

    // Periodic mode, one byte per frame every T_PERIOD cycles
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(INIT); len_q.push_back(1); frames_exp++;
    end
    RST = 1'b0;
    t0  = cyc;
    wait_en_rise("per_en1");
    check_eq("per_first_cycle", cyc - t0, T_PERIOD + 1);
    wait_en_rise("per_en2");
    check_eq("per_second_cycle", cyc - t0, 2 * T_PERIOD + 1);
    wait_fd(2);
    bus.Mode = 1'b1;
    repeat (30) @(negedge CLK);
    check_eq("ondemand_no_period", fd_seen, 2);

    // Returning to periodic mode restarts the count from 0
    bus.Mode = 1'b0;
    t0 = cyc;
    exp_q.push_back(INIT); len_q.push_back(1); frames_exp++;
    wait_en_rise("restart_en");
    check_eq("restart_cycle", cyc - t0, T_PERIOD + 1);
    bus.Mode = 1'b1;
    wait_fd(frames_exp);
    repeat (3) @(negedge CLK);

    // On-demand three-byte frame
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
    start_frame(3);
    wait_en_rise("od_en");
    check_eq("od_latency", cyc - t_trig, 2);
    wait_fd(frames_exp);
    @(negedge CLK);
    check_eq("od_busy_after", 32'(bus.Busy), 0);

    // Length above depth is clipped
    start_frame(7);
    wait_fd(frames_exp);
    repeat (2) @(negedge CLK);

    // Zero length is ignored entirely
    start_frame(0);
    for (int i = 0; i < 5; i++) begin
      check_eq("len0_busy", 32'(bus.Busy), 0);
      @(negedge CLK);
    end
    check_eq("len0_overrun", ovr_seen, ovr_exp);

    // Overwriting an entry already in Tx_Data
    start_frame(2);
    wait_en_rise("ow_en");
    wr(0, 8'hC7);
    @(negedge CLK);
    check_eq("ow_hold", 32'(bus.Tx_Data), 32'h11);
    wait_fd(frames_exp);
    repeat (2) @(negedge CLK);
    start_frame(1);
    wait_fd(frames_exp);
    repeat (2) @(negedge CLK);

    // Trigger during the second byte
    start_frame(3);
    repeat (9) @(negedge CLK);
    pulse_start();
    ovr_exp++;
    wait_fd(frames_exp);
    repeat (20) @(negedge CLK);
    check_eq("ovr_count", ovr_seen, ovr_exp);
    check_eq("ovr_no_second", fd_seen, frames_exp);

    // Asynchronous reset during the second byte
    start_frame(3);
    repeat (9) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check_eq("arst_en",   32'(bus.Tx_En_Sig), 0);
    check_eq("arst_data", 32'(bus.Tx_Data), 32'(INIT));
    check_eq("arst_busy", 32'(bus.Busy), 0);
    exp_q.delete(); len_q.delete(); frames_exp--;
    for (int i = 0; i < DEPTH; i++) shadow[i] = INIT;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    start_frame(4);
    wait_fd(frames_exp);
    repeat (2) @(negedge CLK);

    // Randomized on-demand traffic
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 3);
      for (int w = 0; w < n; w++) wr($urandom_range(0, DEPTH - 1), DATA_W'($urandom_range(0, 255)));
      ml = $urandom_range(0, 7);
      n  = eff_len(ml);
      start_frame(ml);
      if (n == 0) begin
        repeat (3) @(negedge CLK);
        check_eq("rnd_len0_busy", 32'(bus.Busy), 0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(2, 7 * n);
          repeat (k - 1) @(negedge CLK);
          pulse_start();
          ovr_exp++;
        end
        wait_fd(frames_exp);
      end
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    // Final report
    repeat (10) @(negedge CLK);
    check_eq("final_exp_q_empty", exp_q.size(), 0);
    check_eq("final_frames", fd_seen, frames_exp);
    check_eq("final_overruns", ovr_seen, ovr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
